// File: rtl/mod_sched_pkg.sv
// Shared types for the modulo-engine scheduler: FSM state encoding and
// default-configuration index/operand typedefs.
package mod_sched_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 9;
  localparam int unsigned IDXW      = $clog2(NREQ_DEF);

  typedef logic [IDXW-1:0]      idx_t;
  typedef logic [WIDTH_DEF-1:0] operand_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i,
// wrapping NREQ-1 -> 0, returned as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = PW'((32'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[pos]) begin
        grant_o[pos] = 1'b1;
        idx_o        = pos;
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_engine_scheduler.sv
// Round-robin scheduler sharing one serial modulo engine among NREQ requesters.
// Optional WAIT timeout/abort enabled by defining MOD_SCHED_TIMEOUT_EN.
module mod_engine_scheduler
  import mod_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_rem,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  eng_start,
  output logic [WIDTH-1:0]      eng_dividend,
  output logic [WIDTH-1:0]      eng_divisor,
  input  logic                  eng_done,
  input  logic [WIDTH-1:0]      eng_rem,
  output logic                  eng_abort
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  if (NREQ < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("mod_engine_scheduler: NREQ must be >= 2 and TIMEOUT >= 1");
  end

  state_e           state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  grant;
  logic [PW-1:0]    grant_idx;
  logic             grant_any;
  logic             timeout_hit;

  logic [WIDTH-1:0] dvd_a [NREQ];
  logic [WIDTH-1:0] dvs_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign dvd_a[g] = req_dividend[g*WIDTH +: WIDTH];
    assign dvs_a[g] = req_divisor[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

`ifdef MOD_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter is 0 on WAIT entry, so the TIMEOUT-th WAIT cycle sees TIMEOUT-1; eng_done wins a tie.
  assign timeout_hit = (state_q == ST_WAIT) && !eng_done && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          owner_d = grant_idx;
          dvd_d   = dvd_a[grant_idx];
          dvs_d   = dvs_a[grant_idx];
          if (dvs_a[grant_idx] == '0) begin
            err_d   = 1'b1;
            rem_d   = dvd_a[grant_idx];
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          rem_d   = eng_rem;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          rem_d   = dvd_q;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ptr_d   = (owner_q == LAST) ? '0 : owner_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign eng_dividend = dvd_q;
  assign eng_divisor  = dvs_q;

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_rem   = '0;
    rsp_zero  = 1'b0;
    rsp_err   = 1'b0;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    unique case (state_q)
      // Gated by rst_n so no grant is offered while reset is being applied.
      ST_IDLE:  if (rst_n) req_ready = grant;
      ST_ISSUE: eng_start = 1'b1;
      ST_WAIT:  eng_abort = timeout_hit;
      ST_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_rem            = rem_q;
        rsp_zero           = !err_q && (rem_q == '0);
        rsp_err            = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mod_engine_scheduler.sv
// Directed self-checking bench for mod_engine_scheduler with a behavioural
// serial-mod engine; define MOD_SCHED_TIMEOUT_EN to exercise the abort path.
module tb_mod_engine_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 9;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend;
  logic [NREQ*WIDTH-1:0] req_divisor;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_rem;
  logic                  rsp_zero;
  logic                  rsp_err;
  logic                  eng_start;
  logic [WIDTH-1:0]      eng_dividend;
  logic [WIDTH-1:0]      eng_divisor;
  logic                  eng_done;
  logic [WIDTH-1:0]      eng_rem;
  logic                  eng_abort;

  logic [WIDTH-1:0] dvd_a [NREQ];
  logic [WIDTH-1:0] dvs_a [NREQ];

  assign req_dividend = {dvd_a[3], dvd_a[2], dvd_a[1], dvd_a[0]};
  assign req_divisor  = {dvs_a[3], dvs_a[2], dvs_a[1], dvs_a[0]};

  always #5 clk = ~clk;

  mod_engine_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_rem      (rsp_rem),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err),
    .eng_start    (eng_start),
    .eng_dividend (eng_dividend),
    .eng_divisor  (eng_divisor),
    .eng_done     (eng_done),
    .eng_rem      (eng_rem),
    .eng_abort    (eng_abort)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Engine model: three cycles after seeing eng_start it pulses eng_done, unless stalled.
  int   eng_starts  = 0;
  int   rsp_pulses  = 0;
  int   eng_cnt     = 0;
  logic eng_busy    = 1'b0;
  logic eng_stall   = 1'b0;

  initial begin
    eng_done = 1'b0;
    eng_rem  = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (rsp_valid != '0) rsp_pulses++;
      if (!rst_n) begin
        eng_busy = 1'b0;
      end else if (eng_start) begin
        eng_busy = 1'b1;
        eng_cnt  = 3;
        eng_starts++;
      end else if (eng_busy && !eng_stall) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done = 1'b1;
          eng_rem  = (eng_divisor != '0) ? eng_dividend % eng_divisor : eng_dividend;
          eng_busy = 1'b0;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    dvd_a[i]     = dvd;
    dvs_a[i]     = dvs;
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_rsp(input string tag, input logic [NREQ-1:0] v, input logic [WIDTH-1:0] rem,
                            input logic z, input logic e, output int n);
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    check({tag, "_rem"},   32'(rsp_rem),   32'(rem));
    check({tag, "_zero"},  32'(rsp_zero),  32'(z));
    check({tag, "_err"},   32'(rsp_err),   32'(e));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n, s0, p0;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      dvd_a[i] = '0;
      dvs_a[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(req_ready),    0);
    check("rst_rspv",   32'(rsp_valid),    0);
    check("rst_start",  32'(eng_start),    0);
    check("rst_edvd",   32'(eng_dividend), 0);
    check("rst_edvs",   32'(eng_divisor),  0);
    check("rst_abort",  32'(eng_abort),    0);
    check("rst_rem",    32'(rsp_rem),      0);
    rst_n = 1'b1;
    @(negedge clk);

    // 503 mod 14 = 13
    set_req(0, 9'd503, 9'd14);
    #1 check("t1_ready", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("t1_start", 32'(eng_start),    1);
    check("t1_edvd",  32'(eng_dividend), 503);
    check("t1_edvs",  32'(eng_divisor),  14);
    expect_rsp("t1", 4'b0001, 9'd13, 1'b0, 1'b0, n);
    check("t1_lat",    n,          4);
    check("t1_starts", eng_starts, 1);

    // 91 mod 7 = 0
    set_req(1, 9'd91, 9'd7);
    #1 check("t2_ready", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    req_valid[1] = 1'b0;
    expect_rsp("t2", 4'b0010, 9'd0, 1'b1, 1'b0, n);

    // Fresh reset, req0 and req2 together: 20 mod 6 = 2, 17 mod 9 = 8
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 9'd20, 9'd6);
    set_req(2, 9'd17, 9'd9);
    #1 check("t3_ready0", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("t3_busy", 32'(req_ready), 0);
    expect_rsp("t3a", 4'b0001, 9'd2, 1'b0, 1'b0, n);
    check("t3_ready2", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    req_valid[2] = 1'b0;
    expect_rsp("t3b", 4'b0100, 9'd8, 1'b0, 1'b0, n);

    // ptr now 3: req3 (divisor 0) beats req0
    s0 = eng_starts;
    set_req(0, 9'd5, 9'd9);
    set_req(3, 9'd25, 9'd0);
    #1 check("t4_ready3", 32'(req_ready), 32'(4'b1000));
    @(negedge clk);
    req_valid[3] = 1'b0;
    expect_rsp("t4", 4'b1000, 9'd25, 1'b0, 1'b1, n);
    check("t4_lat",    n,          0);
    check("t4_starts", eng_starts, s0);
    check("t5_ready0", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("t5_edvd", 32'(eng_dividend), 5);
    expect_rsp("t5", 4'b0001, 9'd5, 1'b0, 1'b0, n);

    // Reset while in WAIT
    eng_stall = 1'b1;
    set_req(1, 9'd100, 9'd9);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    p0 = rsp_pulses;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_ready", 32'(req_ready),    0);
    check("t6_rspv",  32'(rsp_valid),    0);
    check("t6_start", 32'(eng_start),    0);
    check("t6_edvd",  32'(eng_dividend), 0);
    check("t6_edvs",  32'(eng_divisor),  0);
    check("t6_err",   32'(rsp_err),      0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    eng_stall = 1'b0;
    @(negedge clk);
    check("t6_nopulse", rsp_pulses, p0);
    set_req(1, 9'd100, 9'd9);
    #1 check("t6_ready1", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    req_valid[1] = 1'b0;
    expect_rsp("t6", 4'b0010, 9'd1, 1'b0, 1'b0, n);

`ifdef MOD_SCHED_TIMEOUT_EN
    // Engine never finishes: abort on the 16th WAIT cycle
    eng_stall = 1'b1;
    set_req(2, 9'd40, 9'd3);
    @(negedge clk);
    req_valid[2] = 1'b0;
    n = 1;
    while (!eng_abort && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t7_abort_at", n, 17);
    check("t7_abort", 32'(eng_abort), 1);
    @(negedge clk);
    check("t7_abort_pulse", 32'(eng_abort), 0);
    expect_rsp("t7", 4'b0100, 9'd40, 1'b0, 1'b1, n);
    eng_stall = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
